// File: rtl/audio_irq_pkg.sv
// rtl/audio_irq_pkg.sv - shared register map and field constants for the audio interrupt aggregator
package audio_irq_pkg;

  localparam int DATA_W           = 16;
  localparam int ID_W             = 4;
  localparam int ACTIVE_VALID_BIT = 15;

  localparam logic [2:0] ADDR_PENDING   = 3'd0;
  localparam logic [2:0] ADDR_MASK      = 3'd1;
  localparam logic [2:0] ADDR_EDGE_MODE = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE_ID = 3'd3;
  localparam logic [2:0] ADDR_RAW       = 3'd4;
  localparam logic [2:0] ADDR_SW_SET    = 3'd5;

endpackage

// File: rtl/audio_irq_prio_enc.sv
// rtl/audio_irq_prio_enc.sv - combinational priority encoder, lowest set index wins
module audio_irq_prio_enc
  import audio_irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the last hit is the lowest index; id stays 0 when nothing is set
  always_comb begin
    valid = |vec;
    id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/audio_irq_ctrl.sv
// rtl/audio_irq_ctrl.sv - interrupt latch/mask/priority block with CPU irq line; optional AUDIO_IRQ_HOLDOFF_EN
module audio_irq_ctrl
  import audio_irq_pkg::*;
#(
  parameter int NUM_SRC        = 8,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  input  logic [NUM_SRC-1:0]  irq_src,
  output logic                irq_out
);

  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pend_d;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] sw_set;
  logic [NUM_SRC-1:0] edge_evt;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] masked;
  logic               wr_en;
  logic               act_valid;
  logic [ID_W-1:0]    act_id;
  logic               hold_active;
  logic [DATA_W-1:0]  rd_mux;
  logic               unused_ok;

  assign wr_en    = chipselect & ~write_n;
  assign w1c      = (wr_en && address == ADDR_PENDING) ? writedata[NUM_SRC-1:0] : '0;
  assign sw_set   = (wr_en && address == ADDR_SW_SET)  ? writedata[NUM_SRC-1:0] : '0;
  assign edge_evt = irq_src & ~prev_q;
  assign set_vec  = edge_evt | sw_set;

  // Edge sources: clear first, then OR in sets so a colliding set is never lost.
  // Level sources simply follow irq_src, so writes cannot stick.
  assign pend_d = (edge_q & ((pend_q & ~w1c) | set_vec)) | (~edge_q & irq_src);
  assign masked = pend_q & mask_q;

  audio_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .vec   (masked),
    .valid (act_valid),
    .id    (act_id)
  );

`ifdef AUDIO_IRQ_HOLDOFF_EN
  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  logic [HOLD_W-1:0] holdoff_cnt;
  logic              holdoff_load;

  // Only a write that actually drops a pending bit restarts the quiet window
  assign holdoff_load = |(w1c & pend_q & edge_q & ~set_vec);
  // The loading cycle also gates the line, giving HOLDOFF_CYCLES low cycles in total
  assign hold_active  = holdoff_load | (holdoff_cnt != '0);

  // Holdoff counter: load on a clearing ack, count down and rest at zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      holdoff_cnt <= '0;
    end else if (holdoff_load) begin
      holdoff_cnt <= HOLD_W'(HOLDOFF_CYCLES - 1);
    end else if (holdoff_cnt != '0) begin
      holdoff_cnt <= holdoff_cnt - 1'b1;
    end
  end

  assign unused_ok = &{1'b0, writedata};
`else
  assign hold_active = 1'b0;
  assign unused_ok   = &{1'b0, writedata, HOLDOFF_CYCLES != 0};
`endif

  // Read mux from current (pre-update) register values
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_PENDING:   rd_mux = DATA_W'(pend_q);
      ADDR_MASK:      rd_mux = DATA_W'(mask_q);
      ADDR_EDGE_MODE: rd_mux = DATA_W'(edge_q);
      ADDR_ACTIVE_ID: begin
        rd_mux[ACTIVE_VALID_BIT] = act_valid;
        rd_mux[ID_W-1:0]         = act_id;
      end
      ADDR_RAW:       rd_mux = DATA_W'(irq_src);
      default:        rd_mux = '0;
    endcase
  end

  // Register file, edge history, irq line and registered read data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q   <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      prev_q   <= '1;
      irq_out  <= 1'b0;
      readdata <= '0;
    end else begin
      prev_q   <= irq_src;
      pend_q   <= pend_d;
      if (wr_en && address == ADDR_MASK)      mask_q <= writedata[NUM_SRC-1:0];
      if (wr_en && address == ADDR_EDGE_MODE) edge_q <= writedata[NUM_SRC-1:0];
      irq_out  <= (|masked) & ~hold_active;
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_audio_irq_ctrl.sv
// tb/tb_audio_irq_ctrl.sv - directed self-checking bench for audio_irq_ctrl
module tb_audio_irq_ctrl;
  import audio_irq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_src;
  logic        irq_out;
  logic [15:0] rd;

  int checks = 0;
  int errors = 0;

`ifdef AUDIO_IRQ_HOLDOFF_EN
  localparam logic [15:0] ACK_SAME_CYCLE_IRQ = 16'h0;
`else
  localparam logic [15:0] ACK_SAME_CYCLE_IRQ = 16'h1;
`endif

  always #5 clk = ~clk;

  audio_irq_ctrl #(.NUM_SRC(8), .HOLDOFF_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_src    (irq_src),
    .irq_out    (irq_out)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (20) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 3'd0; writedata = 16'h0; irq_src = 8'hFF;
    repeat (3) tick();
    check_val("rst_irq_out", irq_out, 16'h0);
    check_val("rst_readdata", readdata, 16'h0);
    reset_n = 1'b1;
    bus_read(ADDR_PENDING, rd);
    check_val("rst_pending", rd, 16'h0);
    check_val("rst_irq_rel", irq_out, 16'h0);

    // edge latch on source 0
    irq_src = 8'h00;
    bus_write(ADDR_EDGE_MODE, 16'h00FF);
    bus_write(ADDR_MASK, 16'h0001);
    bus_read(ADDR_PENDING, rd);
    check_val("edge_idle_pend", rd, 16'h0);
    irq_src = 8'h01; tick(); irq_src = 8'h00;
    check_val("edge_irq_lat0", irq_out, 16'h0);
    tick();
    check_val("edge_irq_lat1", irq_out, 16'h1);
    bus_read(ADDR_PENDING, rd);
    check_val("edge_pend", rd, 16'h0001);
    bus_read(ADDR_ACTIVE_ID, rd);
    check_val("edge_active", rd, 16'h8000);
    bus_write(ADDR_PENDING, 16'h0001);
    check_val("w1c_irq_same", irq_out, ACK_SAME_CYCLE_IRQ);
    tick();
    check_val("w1c_irq_drop", irq_out, 16'h0);
    settle();

    // priority among masked sources
    bus_write(ADDR_MASK, 16'h000C);
    irq_src = 8'h0C; tick(); irq_src = 8'h00;
    bus_read(ADDR_ACTIVE_ID, rd);
    check_val("prio_2", rd, 16'h8002);
    bus_write(ADDR_PENDING, 16'h0004);
    bus_read(ADDR_ACTIVE_ID, rd);
    check_val("prio_3", rd, 16'h8003);
    irq_src = 8'h01; tick(); irq_src = 8'h00;
    bus_read(ADDR_ACTIVE_ID, rd);
    check_val("prio_masked", rd, 16'h8003);
    bus_write(ADDR_PENDING, 16'h00FF);
    bus_read(ADDR_ACTIVE_ID, rd);
    check_val("prio_none", rd, 16'h0000);
    settle();

    // ack colliding with a new edge on the same bit
    bus_write(ADDR_MASK, 16'h0001);
    irq_src = 8'h01; tick(); irq_src = 8'h00; tick();
    check_val("coll_pre", irq_out, 16'h1);
    address = ADDR_PENDING; writedata = 16'h0001; chipselect = 1'b1; write_n = 1'b0;
    irq_src = 8'h01;
    tick();
    chipselect = 1'b0; write_n = 1'b1; irq_src = 8'h00;
    check_val("coll_irq0", irq_out, 16'h1);
    bus_read(ADDR_PENDING, rd);
    check_val("coll_pend", rd, 16'h0001);
    check_val("coll_irq1", irq_out, 16'h1);
    bus_write(ADDR_PENDING, 16'h0001);
    settle();

    // software set
    bus_write(ADDR_MASK, 16'h0080);
    bus_write(ADDR_SW_SET, 16'h0080);
    check_val("swset_lat0", irq_out, 16'h0);
    tick();
    check_val("swset_lat1", irq_out, 16'h1);
    bus_read(ADDR_PENDING, rd);
    check_val("swset_pend", rd, 16'h0080);
    bus_read(ADDR_SW_SET, rd);
    check_val("swset_read0", rd, 16'h0000);
    bus_write(ADDR_PENDING, 16'h0080);
    settle();

    // level mode with mask
    bus_write(ADDR_MASK, 16'h0000);
    bus_write(ADDR_EDGE_MODE, 16'h0000);
    irq_src = 8'h02; tick();
    bus_read(ADDR_PENDING, rd);
    check_val("lvl_pend", rd, 16'h0002);
    check_val("lvl_irq_masked", irq_out, 16'h0);
    bus_read(ADDR_RAW, rd);
    check_val("lvl_raw", rd, 16'h0002);
    bus_write(ADDR_MASK, 16'h0002);
    tick();
    check_val("lvl_irq_on", irq_out, 16'h1);
    bus_write(ADDR_PENDING, 16'h0002);
    bus_read(ADDR_PENDING, rd);
    check_val("lvl_w1c_noeff", rd, 16'h0002);
    irq_src = 8'h00; tick();
    check_val("lvl_drop0", irq_out, 16'h1);
    bus_read(ADDR_PENDING, rd);
    check_val("lvl_drop_pend", rd, 16'h0000);
    check_val("lvl_drop1", irq_out, 16'h0);
    bus_read(ADDR_MASK, rd);
    check_val("mask_readback", rd, 16'h0002);
    bus_read(ADDR_EDGE_MODE, rd);
    check_val("edge_readback", rd, 16'h0000);
    bus_read(3'd6, rd);
    check_val("unmapped_6", rd, 16'h0000);

    // mask clear keeps pending
    irq_src = 8'h02; tick(); tick();
    check_val("mclr_pre", irq_out, 16'h1);
    bus_write(ADDR_MASK, 16'h0000);
    check_val("mclr_irq0", irq_out, 16'h1);
    tick();
    check_val("mclr_irq1", irq_out, 16'h0);
    bus_read(ADDR_PENDING, rd);
    check_val("mclr_pend", rd, 16'h0002);

    // reset mid-operation
    irq_src = 8'h00;
    bus_write(ADDR_MASK, 16'h00FF);
    bus_write(ADDR_EDGE_MODE, 16'h00FF);
    bus_write(ADDR_SW_SET, 16'h0055);
    tick();
    check_val("mrst_pre", irq_out, 16'h1);
    reset_n = 1'b0; tick(); tick();
    check_val("mrst_irq", irq_out, 16'h0);
    reset_n = 1'b1;
    bus_read(ADDR_PENDING, rd);
    check_val("mrst_pend0", rd, 16'h0000);
    bus_read(ADDR_MASK, rd);
    check_val("mrst_mask", rd, 16'h0000);
    bus_read(ADDR_PENDING, rd);
    check_val("mrst_pend1", rd, 16'h0000);

`ifdef AUDIO_IRQ_HOLDOFF_EN
    // holdoff window after an ack with another source still pending
    bus_write(ADDR_EDGE_MODE, 16'h00FF);
    bus_write(ADDR_MASK, 16'h00FF);
    irq_src = 8'h03; tick(); irq_src = 8'h00; tick(); tick();
    check_val("hold_pre", irq_out, 16'h1);
    bus_write(ADDR_PENDING, 16'h0001);
    check_val("hold_k0", irq_out, 16'h0);
    for (int k = 1; k < 16; k++) begin
      if (k == 5) begin
        address = ADDR_SW_SET; writedata = 16'h0080; chipselect = 1'b1; write_n = 1'b0;
      end
      tick();
      chipselect = 1'b0; write_n = 1'b1;
      check_val("hold_low", irq_out, 16'h0);
    end
    tick();
    check_val("hold_end", irq_out, 16'h1);
    bus_read(ADDR_PENDING, rd);
    check_val("hold_pend", rd, 16'h0082);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
